// File: rtl/sram_like_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_like_arbiter_if : CPU inst/data ports plus shared memory port   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sram_like_arbiter_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        proto_err;

  // The arbiter itself
  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    input  data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output proto_err
  );

  // The surrounding CPU and memory
  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
    output data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  proto_err
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_like_arbiter : data-over-inst 2:1 SRAM-like arbiter with an     |
// | in-order source FIFO routing each response back to its requester.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram_like_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int OUTST_W   = $clog2(MAX_OUTST)
) (
  input  logic                clk,
  input  logic                reset,
  sram_like_arbiter_if.slave  bus
);

  localparam logic [OUTST_W:0]   C_FULL_CNT = (OUTST_W+1)'(MAX_OUTST);
  localparam logic [OUTST_W:0]   C_CNT_ONE  = (OUTST_W+1)'(1);
  localparam logic [OUTST_W-1:0] C_PTR_ONE  = OUTST_W'(1);

  logic [OUTST_W:0]     cnt_q, cnt_d;
  logic [OUTST_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OUTST_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [MAX_OUTST-1:0] fifo_q, fifo_d;
  logic                 proto_err_q, proto_err_d;

  logic w_full, w_empty, w_gnt_d, w_gnt_i, w_push, w_pop, w_head_src;

  assign w_full     = (cnt_q == C_FULL_CNT);
  assign w_empty    = (cnt_q == '0);
  assign w_head_src = fifo_q[rd_ptr_q];

  // Full blocks grants even if a pop lands in the same cycle: no data_ok->req path.
  assign w_gnt_d = ~reset & bus.data_sram_req & ~w_full;
  assign w_gnt_i = ~reset & bus.inst_sram_req & ~bus.data_sram_req & ~w_full;
  assign w_push  = (w_gnt_d | w_gnt_i) & bus.mem_addr_ok;
  assign w_pop   = ~reset & bus.mem_data_ok & ~w_empty;

  assign bus.mem_req   = w_gnt_d | w_gnt_i;
  assign bus.mem_wr    = bus.data_sram_req ? bus.data_sram_wr    : bus.inst_sram_wr;
  assign bus.mem_size  = bus.data_sram_req ? bus.data_sram_size  : bus.inst_sram_size;
  assign bus.mem_wstrb = bus.data_sram_req ? bus.data_sram_wstrb : bus.inst_sram_wstrb;
  assign bus.mem_addr  = bus.data_sram_req ? bus.data_sram_addr  : bus.inst_sram_addr;
  assign bus.mem_wdata = bus.data_sram_req ? bus.data_sram_wdata : bus.inst_sram_wdata;

  assign bus.data_sram_addr_ok = w_gnt_d & bus.mem_addr_ok;
  assign bus.inst_sram_addr_ok = w_gnt_i & bus.mem_addr_ok;

  assign bus.data_sram_data_ok = w_pop &  w_head_src;
  assign bus.inst_sram_data_ok = w_pop & ~w_head_src;
  assign bus.data_sram_rdata   = bus.mem_rdata;
  assign bus.inst_sram_rdata   = bus.mem_rdata;

  assign bus.proto_err = proto_err_q;

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q | (bus.mem_data_ok & w_empty);
    if (w_push) begin
      fifo_d[wr_ptr_q] = w_gnt_d;
      wr_ptr_d         = wr_ptr_q + C_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    end
    if (w_push && !w_pop) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end else if (!w_push && w_pop) begin
      cnt_d = cnt_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_q      <= fifo_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
`default_nettype wire
